output_port_allocator: RTL

OUTPUT_PORT_ALLOCATOR -- requirements
Module: output_port_allocator

---
 rtl/output_port_allocator_pkg.sv | 18 +
 rtl/output_port_allocator_rr_arbiter.sv | 35 +++
 rtl/output_port_allocator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/output_port_allocator_pkg.sv
// Shared NoC definitions for the output port allocator: flit-type encodings,
// allocator FSM states and the packet-counter width.
package output_port_allocator_pkg;

  localparam int NOC_FLIT_ID_W = 2;

  localparam logic [NOC_FLIT_ID_W-1:0] HEADER_ID = 2'd0;
  localparam logic [NOC_FLIT_ID_W-1:0] BODY_ID   = 2'd1;
  localparam logic [NOC_FLIT_ID_W-1:0] TAIL_ID   = 2'd2;

  localparam int PKT_CNT_W = 16;

  typedef enum logic {
    OPA_IDLE   = 1'b0,
    OPA_LOCKED = 1'b1
  } opa_state_e;

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping from N-1 back to 0. Returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int N_W = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [N_W-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [N_W-1:0] idx_o
);

  logic           found;
  int             cand;
  logic [N_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = N_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Output port allocator: locks the output to one VC per packet, round-robin.
// Define OPA_PKT_CNT_EN to add the saturating tail-transfer counter pkt_cnt_o.
module output_port_allocator
  import output_port_allocator_pkg::*;
#(
  parameter int VC_NUM    = 4,
  parameter int VC_NUM_W  = 2,
  parameter int OUT_N_W   = 3,
  parameter int PORT_ID   = 0,
  parameter int FLIT_ID_W = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [VC_NUM*OUT_N_W-1:0]    route_res_i,
  input  logic [VC_NUM-1:0]            route_res_vld_i,
  input  logic [VC_NUM-1:0]            data_vld_i,
  input  logic [VC_NUM*FLIT_ID_W-1:0]  flit_id_i,
  input  logic                         out_rdy_i,
  output logic [VC_NUM-1:0]            chan_alloc_o,
  output logic [VC_NUM_W-1:0]          sel_o,
  output logic                         sel_vld_o,
  output logic                         err_o
`ifdef OPA_PKT_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0]         pkt_cnt_o
`endif
);

  opa_state_e           state_q, state_d;
  logic [VC_NUM_W-1:0]  g_q, g_d;
  logic [VC_NUM_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic                 started_q, started_d;
  logic                 err_q, err_d;

  logic [VC_NUM-1:0]    req;
  logic [VC_NUM-1:0]    arb_gnt;
  logic [VC_NUM_W-1:0]  arb_idx;
  logic                 data_vld_g;
  logic [FLIT_ID_W-1:0] flit_g;
  logic                 xfer, xfer_tail, xfer_hdr_err;

  always_comb begin
    req = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      req[i] = route_res_vld_i[i] &&
               (route_res_i[i*OUT_N_W +: OUT_N_W] == OUT_N_W'(PORT_ID));
    end
  end

  rr_arbiter #(
    .N   (VC_NUM),
    .N_W (VC_NUM_W)
  ) u_rr_arbiter (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Only the locked VC's handshake and flit type are observed.
  always_comb begin
    data_vld_g = 1'b0;
    flit_g     = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      if (g_q == VC_NUM_W'(i)) begin
        data_vld_g = data_vld_i[i];
        flit_g     = flit_id_i[i*FLIT_ID_W +: FLIT_ID_W];
      end
    end
  end

  assign xfer         = (state_q == OPA_LOCKED) && data_vld_g && out_rdy_i;
  assign xfer_tail    = xfer && (flit_g == FLIT_ID_W'(TAIL_ID));
  assign xfer_hdr_err = xfer && started_q && (flit_g == FLIT_ID_W'(HEADER_ID));

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rr_ptr_d  = rr_ptr_q;
    started_d = started_q;
    err_d     = xfer_hdr_err;
    unique case (state_q)
      OPA_IDLE: begin
        if (|arb_gnt) begin
          state_d   = OPA_LOCKED;
          g_d       = arb_idx;
          started_d = 1'b0;
        end
      end
      OPA_LOCKED: begin
        if (xfer) started_d = 1'b1;
        // Requests seen during the tail cycle wait for the next IDLE cycle.
        if (xfer_tail) begin
          state_d  = OPA_IDLE;
          rr_ptr_d = (g_q == VC_NUM_W'(VC_NUM-1)) ? '0 : g_q + VC_NUM_W'(1);
        end
      end
      default: state_d = OPA_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= OPA_IDLE;
      g_q       <= '0;
      rr_ptr_q  <= '0;
      started_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_ptr_q  <= rr_ptr_d;
      started_q <= started_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    chan_alloc_o = '0;
    sel_o        = '0;
    sel_vld_o    = 1'b0;
    if (state_q == OPA_LOCKED) begin
      for (int i = 0; i < VC_NUM; i++) begin
        chan_alloc_o[i] = (g_q == VC_NUM_W'(i));
      end
      sel_o     = g_q;
      sel_vld_o = 1'b1;
    end
  end

  assign err_o = err_q;

`ifdef OPA_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (xfer_tail && (pkt_cnt_q != '1)) pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pkt_cnt_q <= '0;
    else       pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule
